// File: rtl/register_file_pkg.sv
// Shared widths, register indices and data types for the CPU register file.
// Build option REGISTER_FILE_BYPASS_EN enables same-cycle write-through on the read ports.
package register_file_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
    localparam int R0_IDX         = 0;

    typedef logic [DEFAULT_DATA_W-1:0] data_t;
    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/register_file_rd_port.sv
// One combinational read port: selects a stored register and, when REGISTER_FILE_BYPASS_EN
// is defined, forwards the data being written in the current cycle.
module register_file_rd_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd0,
    output logic [DATA_W-1:0] rd
);

    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

`ifdef REGISTER_FILE_BYPASS_EN
    // The addressed write beats the R0 side-write, matching the collision rule on the store.
    always_comb begin
        rd = regs[rr];
        if (we) begin
            if (rr == wa) begin
                rd = wd1;
            end else if (rr == R0_ADDR) begin
                rd = wd0;
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, we, wa, wd1, wd0, R0_ADDR};

    always_comb begin
        rd = regs[rr];
    end
`endif

endmodule

// File: rtl/register_file.sv
// 16x16 register file: two addressed read ports, a fixed R0 read port, and a dual-result write
// (WD1 to register[WA], WD0 to R0). REGISTER_FILE_BYPASS_EN adds same-cycle forwarding.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic [DATA_W-1:0] RD0,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int                NREGS   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

    logic [DATA_W-1:0] regs [NREGS];
    logic              fwd_en;

    // Forwarding is only meaningful when the edge will actually commit the write.
    assign fwd_en = regWrite & rst;

    // The WA write is issued last so that WA==0 lets WD1 override the WD0 side-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite) begin
            regs[R0_ADDR] <= WD0;
            regs[WA]      <= WD1;
        end
    end

    register_file_rd_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rd1 (
        .regs(regs),
        .rr  (RR1),
        .we  (fwd_en),
        .wa  (WA),
        .wd1 (WD1),
        .wd0 (WD0),
        .rd  (RD1)
    );

    register_file_rd_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_rd2 (
        .regs(regs),
        .rr  (RR2),
        .we  (fwd_en),
        .wa  (WA),
        .wd1 (WD1),
        .wd0 (WD0),
        .rd  (RD2)
    );

`ifdef REGISTER_FILE_BYPASS_EN
    always_comb begin
        RD0 = regs[R0_ADDR];
        if (fwd_en) begin
            RD0 = (WA == R0_ADDR) ? WD1 : WD0;
        end
    end
`else
    always_comb begin
        RD0 = regs[R0_ADDR];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: table vectors, random writes against a reference array,
// and hand sequences for asynchronous reset and same-cycle read behaviour.
module tb_register_file;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          regWrite;
    logic [AW-1:0] WA;
    logic [DW-1:0] WD1;
    logic [DW-1:0] WD0;
    logic [AW-1:0] RR1;
    logic [AW-1:0] RR2;
    logic [DW-1:0] RD0;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .regWrite(regWrite),
        .WA      (WA),
        .WD1     (WD1),
        .WD0     (WD0),
        .RR1     (RR1),
        .RR2     (RR2),
        .RD0     (RD0),
        .RD1     (RD1),
        .RD2     (RD2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [3*DW-1:0] exp_q[$];
    logic [DW-1:0]   model [2**AW];

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd1;
        logic [DW-1:0] wd0;
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name);
        logic [3*DW-1:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_empty_queue act=0 exp=1", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rd0"}, RD0, e[3*DW-1:2*DW]);
            check({name, "_rd1"}, RD1, e[2*DW-1:DW]);
            check({name, "_rd2"}, RD2, e[DW-1:0]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
    endtask

    // driver: present a write (or idle cycle) for one rising edge, then idle with X data
    task automatic drive_write(input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        @(negedge clk);
        regWrite = we;
        WA       = wa;
        WD1      = d1;
        WD0      = d0;
        @(posedge clk);
        if (we === 1'b1) begin
            model[0]  = d0;
            model[wa] = d1;
        end
        #1;
        regWrite = 1'b0;
        WA       = 'x;
        WD1      = 'x;
        WD0      = 'x;
    endtask

    task automatic drive_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                              input logic [3*DW-1:0] exp, input string name);
        RR1 = r1;
        RR2 = r2;
        exp_q.push_back(exp);
        #1;
        sb_compare(name);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd3,  16'h0005, 16'h0008, 4'd3,  4'd8,  16'h0008, 16'h0005, 16'h0000};
        vecs[1] = '{1'b1, 4'd4,  16'h0005, 16'h0008, 4'd4,  4'd3,  16'h0008, 16'h0005, 16'h0005};
        vecs[2] = '{1'b1, 4'd10, 16'h0005, 16'h0008, 4'd4,  4'd10, 16'h0008, 16'h0005, 16'h0005};
        vecs[3] = '{1'b0, 'x,    'x,       'x,       4'd3,  4'd8,  16'h0008, 16'h0005, 16'h0000};
        vecs[4] = '{1'b0, 'x,    'x,       'x,       4'd10, 4'd0,  16'h0008, 16'h0005, 16'h0008};
        vecs[5] = '{1'b1, 4'd0,  16'h1234, 16'hABCD, 4'd0,  4'd3,  16'h1234, 16'h1234, 16'h0005};
        vecs[6] = '{1'b1, 4'd15, 16'hBEEF, 16'h0001, 4'd15, 4'd0,  16'h0001, 16'hBEEF, 16'h0001};
        vecs[7] = '{1'b1, 4'd15, 16'hCAFE, 16'h0002, 4'd15, 4'd15, 16'h0002, 16'hCAFE, 16'hCAFE};
        vecs[8] = '{1'b0, 'x,    'x,       'x,       4'd15, 4'd4,  16'h0002, 16'hCAFE, 16'h0005};

        rst      = 1'b0;
        regWrite = 1'b0;
        WA       = '0;
        WD1      = '0;
        WD0      = '0;
        RR1      = 4'd3;
        RR2      = 4'd8;
        model_clear();

        // reset held, then released
        #12;
        drive_read(4'd3, 4'd8, '0, "in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        drive_read(4'd3, 4'd8, '0, "after_reset");

        // table vectors
        for (int i = 0; i < 9; i++) begin
            drive_write(vecs[i].we, vecs[i].wa, vecs[i].wd1, vecs[i].wd0);
            drive_read(vecs[i].rr1, vecs[i].rr2, {vecs[i].e0, vecs[i].e1, vecs[i].e2},
                       $sformatf("vec%0d", i));
        end

        // same-cycle read of a write in flight (model currently: r0=0002, r5=0)
        @(negedge clk);
        regWrite = 1'b1;
        WA       = 4'd5;
        WD1      = 16'h00FF;
        WD0      = 16'h0077;
        RR1      = 4'd5;
        RR2      = 4'd0;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        check("bypass_rd1", RD1, 16'h00FF);
        check("bypass_rd2", RD2, 16'h0077);
        check("bypass_rd0", RD0, 16'h0077);
`else
        check("nobypass_rd1", RD1, model[5]);
        check("nobypass_rd2", RD2, model[0]);
        check("nobypass_rd0", RD0, model[0]);
`endif
        @(posedge clk);
        model[0] = 16'h0077;
        model[5] = 16'h00FF;
        #1;
        regWrite = 1'b0;
        WA       = 'x;
        WD1      = 'x;
        WD0      = 'x;
        drive_read(4'd5, 4'd0, {16'h0077, 16'h00FF, 16'h0077}, "post_bypass");

        // random writes against the reference array
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a, r1, r2;
            logic [DW-1:0] d1, d0;
            a  = AW'($urandom_range(0, 15));
            d1 = DW'($urandom_range(0, 65535));
            d0 = DW'($urandom_range(0, 65535));
            r1 = AW'($urandom_range(0, 15));
            r2 = (i % 3 == 0) ? a : AW'($urandom_range(0, 15));
            drive_write(($urandom_range(0, 3) != 0), a, d1, d0);
            drive_read(r1, r2, {model[0], model[r1], model[r2]}, $sformatf("rand%0d", i));
        end

        // asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        #2;
        RR1 = 4'd5;
        RR2 = 4'd15;
        rst = 1'b0;
        #1;
        model_clear();
        drive_read(4'd5, 4'd15, '0, "async_reset");

        // reset wins over a write presented across an edge
        regWrite = 1'b1;
        WA       = 4'd7;
        WD1      = 16'h5A5A;
        WD0      = 16'hA5A5;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        drive_read(4'd7, 4'd0, '0, "reset_priority");
        @(negedge clk);
        rst = 1'b1;
        #1;
        drive_read(4'd7, 4'd0, '0, "reset_release");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry × 16-bit general-purpose register file for the pipelined CPU. Decode stage reads from it; writeback stage writes to it.
- Two addressed combinational read ports, plus a dedicated read port that always shows R0.
- Dual-result write: primary data goes to the addressed register, secondary data goes to R0. This carries instructions with two results, such as the multiply high word or the divide remainder.

Parameters:
- DATA_W, 16, width of each register and data port.
- ADDR_W, 4, address width; register count = 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- regWrite  input  1  write enable for the current cycle.
- WA  input  ADDR_W  write address for WD1.
- WD1  input  DATA_W  primary write data, written to register[WA].
- WD0  input  DATA_W  secondary write data, always written to R0.
- RR1  input  ADDR_W  read address, port 1.
- RR2  input  ADDR_W  read address, port 2.
- RD0  output  DATA_W  current contents of R0 (fixed port).
- RD1  output  DATA_W  contents of register[RR1].
- RD2  output  DATA_W  contents of register[RR2].

Behaviour:
- Storage: 2**ADDR_W registers, each DATA_W wide. R0 is an ordinary writable register; it is not hardwired to zero.
- Reset: while rst=0, every register is forced to 0 immediately, without waiting for a clock edge. RD0, RD1 and RD2 therefore read 0. Reset has priority over any write in progress.
- Write: on a rising clk edge with rst=1 and regWrite=1:
  - register[WA] <= WD1;
  - R0 <= WD0.
  - Both updates happen in the same edge.
- Collision WA=0 with regWrite=1: WD1 wins, so R0 <= WD1 and WD0 is discarded.
- regWrite=0: no register changes. WA, WD1 and WD0 are don't-care and may be X without corrupting state.
- Reads are purely combinational from stored state:
  - RD1 = register[RR1];
  - RD2 = register[RR2];
  - RD0 = R0.
- Write latency: a write becomes visible on the read ports after the clock edge (one-cycle visibility), unless the bypass option below is compiled in.
- RR1 and RR2 may be equal, or equal to WA. Each port is independent.
- X on RR1/RR2 yields X on that read port only; stored state is unaffected.

Optional Feature:
- Macro: REGISTER_FILE_BYPASS_EN.
- Defined: write-through forwarding while rst=1 and regWrite=1, applied in this order:
  - RD1 = WD1 if RR1==WA; otherwise, if RR1==0, RD1 = WD0; otherwise RD1 = stored value.
  - RD2 follows the same rule using RR2.
  - RD0 = WD1 if WA==0, otherwise WD0.
  - Forwarding is combinational and resolves the same-cycle writeback/decode hazard.
- Undefined: reads always return stored state; new data is visible only after the edge.

Decomposition:
- Shared package register_file_pkg:
  - DATA_W and ADDR_W defaults;
  - constant NUM_REGS;
  - constant R0_IDX = 0;
  - typedefs data_t (logic [DATA_W-1:0]) and addr_t (logic [ADDR_W-1:0]).
- One natural sub-module, register_file_rd_port: a combinational read mux with the optional bypass. It is instantiated twice, for RD1 and RD2. RD0 uses a direct tap with its own bypass term.

Test Plan:
- Reset: rst=0, then release; RR1=3, RR2=8 → RD0=0, RD1=0, RD2=0. Then assert rst=0 mid-cycle after writes → all outputs 0 immediately, with no clock edge.
- Dual write:
  - Stimulus: regWrite=1, WA=3, WD1=0x0005, WD0=0x0008, one edge, then RR1=3, RR2=8.
  - Response: RD1=0x0005, RD2=0x0000, RD0=0x0008.
- Second write:
  - Stimulus: WA=4, WD1=0x0005, WD0=0x0008, then WA=10, same data; read RR1=4, RR2=10 afterwards.
  - Response: RD1=0x0005, RD2=0x0005, RD0=0x0008, register 3 still 0x0005.
- No write:
  - Stimulus: regWrite=0, WA/WD1/WD0=X for several edges.
  - Response: RR1=3 gives 0x0005, RR2=8 gives 0x0000, RD0=0x0008, with no X anywhere.
- Collision:
  - Stimulus: regWrite=1, WA=0, WD1=0x1234, WD0=0xABCD, one edge.
  - Response: RD0=0x1234.
- Bypass (macro defined):
  - Stimulus: regWrite=1, WA=5, WD1=0x00FF, WD0=0x0077, RR1=5, RR2=0 before the edge.
  - Response: RD1=0x00FF, RD2=0x0077, RD0=0x0077 in the same cycle.
  - Without the macro, the same stimulus gives the old values until the edge.
